shot_resolver: RTL and testbench

- Upstream controller for the 10x10 grid cell array.
- Accepts one fire request at a time as a row/col coordinate and checks it against the ship placement map.
- Drives the per-cell is_ship level, the one-cycle shot pulse and the one-cycle ship_sunk pulse vectors that the grid cells consume.
- Tracks hits per ship, ships remaining and game over, and returns a result code per request.

---
 rtl/battleship_pkg.sv | 26 ++
 rtl/shot_resolver_sunk_mask_gen.sv | 41 ++++
 rtl/shot_resolver.sv | 174 +++++++++++++++++
 tb/tb_shot_resolver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared grid dimensions, result codes and FSM encoding for the shot resolver.
package battleship_pkg;

  localparam int GRID_DIM  = 10;
  localparam int NUM_CELLS = GRID_DIM * GRID_DIM;
  localparam int SHIP_ID_W = 3;

  localparam logic [1:0] RES_MISS   = 2'd0;
  localparam logic [1:0] RES_HIT    = 2'd1;
  localparam logic [1:0] RES_SUNK   = 2'd2;
  localparam logic [1:0] RES_REJECT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_SHOT,
    ST_SINK,
    ST_RESP
  } state_t;

  // Ids above the configured ship count behave exactly like water.
  function automatic logic id_is_ship(input logic [SHIP_ID_W-1:0] id, input int num_ships);
    return (id != '0) && (int'(id) <= num_ships);
  endfunction

endpackage

// File: rtl/shot_resolver_sunk_mask_gen.sv
// Builds the ship_sunk mask for one ship id from the placement map.
// With SUNK_ADJACENT_EN defined the mask also covers every 8-neighbour of the ship.
module sunk_mask_gen
  import battleship_pkg::*;
(
  input  logic [NUM_CELLS*SHIP_ID_W-1:0] ship_map,
  input  logic [SHIP_ID_W-1:0]           ship_id,
  output logic [NUM_CELLS-1:0]           mask
);

  logic [NUM_CELLS-1:0] own;

  always_comb begin
    own = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      own[i] = (ship_id != '0) && (ship_map[i*SHIP_ID_W +: SHIP_ID_W] == ship_id);
    end
  end

`ifdef SUNK_ADJACENT_EN
  always_comb begin
    mask = '0;
    for (int r = 0; r < GRID_DIM; r++) begin
      for (int c = 0; c < GRID_DIM; c++) begin
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((r + dr >= 0) && (r + dr < GRID_DIM) && (c + dc >= 0) && (c + dc < GRID_DIM)) begin
              if (own[(r + dr) * GRID_DIM + (c + dc)]) begin
                mask[r * GRID_DIM + c] = 1'b1;
              end
            end
          end
        end
      end
    end
  end
`else
  assign mask = own;
`endif

endmodule

// File: rtl/shot_resolver.sv
// Resolves one fire request at a time against the ship map and drives grid cell pulses.
// Optional macro SUNK_ADJACENT_EN widens the sunk mask to the ship's neighbours.
module shot_resolver
  import battleship_pkg::*;
#(
  parameter int                     NUM_SHIPS = 5,
  parameter logic [3*NUM_SHIPS-1:0] SHIP_LENS = 15'h26E5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fire_valid,
  output logic         fire_ready,
  input  logic [3:0]   fire_row,
  input  logic [3:0]   fire_col,
  input  logic [299:0] ship_map,
  output logic [99:0]  is_ship,
  output logic [99:0]  shot,
  output logic [99:0]  ship_sunk,
  output logic         result_valid,
  output logic [1:0]   result_code,
  output logic [2:0]   ships_remaining,
  output logic         game_over
);

  state_t               state_q, state_d;
  logic [3:0]           row_q, row_d, col_q, col_d;
  logic [NUM_CELLS-1:0] fired_q, fired_d;
  logic [NUM_CELLS-1:0] shot_q, shot_d;
  logic [NUM_CELLS-1:0] ship_sunk_q, ship_sunk_d;
  logic [2:0]           hit_q [NUM_SHIPS];
  logic [2:0]           hit_d [NUM_SHIPS];
  logic [2:0]           ships_rem_q, ships_rem_d;
  logic                 game_over_q, game_over_d;
  logic                 result_valid_q, result_valid_d;
  logic [1:0]           result_code_q, result_code_d;

  logic                 in_range;
  logic [6:0]           idx;
  logic [8:0]           map_base;
  logic [SHIP_ID_W-1:0] target_id;
  logic                 target_is_ship;
  logic [2:0]           ship_idx;
  logic [2:0]           ship_len [NUM_SHIPS];
  logic [NUM_CELLS-1:0] sunk_mask;

  for (genvar k = 0; k < NUM_SHIPS; k++) begin : g_len
    assign ship_len[k] = SHIP_LENS[3*k +: 3];
  end

  assign in_range       = (row_q < 4'(GRID_DIM)) && (col_q < 4'(GRID_DIM));
  assign idx            = 7'(row_q) * 7'(GRID_DIM) + 7'(col_q);
  assign map_base       = 9'(idx) * 9'd3;
  assign target_id      = ship_map[map_base +: SHIP_ID_W];
  assign target_is_ship = id_is_ship(target_id, NUM_SHIPS);
  assign ship_idx       = target_id - 3'd1;

  sunk_mask_gen u_sunk_mask_gen (
    .ship_map (ship_map),
    .ship_id  (target_id),
    .mask     (sunk_mask)
  );

  always_comb begin
    is_ship = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      is_ship[i] = id_is_ship(ship_map[i*SHIP_ID_W +: SHIP_ID_W], NUM_SHIPS);
    end
  end

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    fired_d        = fired_q;
    hit_d          = hit_q;
    ships_rem_d    = ships_rem_q;
    shot_d         = '0;
    ship_sunk_d    = '0;
    result_valid_d = 1'b0;
    result_code_d  = result_code_q;

    case (state_q)
      ST_IDLE: begin
        if (fire_valid && !game_over_q) begin
          row_d   = fire_row;
          col_d   = fire_col;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (!in_range || fired_q[idx]) begin
          result_code_d  = RES_REJECT;
          result_valid_d = 1'b1;
          state_d        = ST_RESP;
        end else begin
          shot_d[idx]  = 1'b1;
          fired_d[idx] = 1'b1;
          state_d      = ST_SHOT;
        end
      end
      ST_SHOT: begin
        result_valid_d = 1'b1;
        state_d        = ST_RESP;
        if (!target_is_ship) begin
          result_code_d = RES_MISS;
        end else begin
          result_code_d = RES_HIT;
          // Only a real increment can sink, so zero-length ships and extra map cells never re-sink.
          if (hit_q[ship_idx] < ship_len[ship_idx]) begin
            hit_d[ship_idx] = hit_q[ship_idx] + 3'd1;
            if (hit_d[ship_idx] == ship_len[ship_idx]) begin
              ships_rem_d    = ships_rem_q - 3'd1;
              ship_sunk_d    = sunk_mask;
              result_code_d  = RES_SUNK;
              result_valid_d = 1'b0;
              state_d        = ST_SINK;
            end
          end
        end
      end
      ST_SINK: begin
        result_valid_d = 1'b1;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    game_over_d = game_over_q | (ships_rem_d == 3'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      row_q          <= '0;
      col_q          <= '0;
      fired_q        <= '0;
      for (int k = 0; k < NUM_SHIPS; k++) begin
        hit_q[k] <= '0;
      end
      ships_rem_q    <= 3'(NUM_SHIPS);
      game_over_q    <= 1'b0;
      shot_q         <= '0;
      ship_sunk_q    <= '0;
      result_valid_q <= 1'b0;
      result_code_q  <= RES_MISS;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      fired_q        <= fired_d;
      hit_q          <= hit_d;
      ships_rem_q    <= ships_rem_d;
      game_over_q    <= game_over_d;
      shot_q         <= shot_d;
      ship_sunk_q    <= ship_sunk_d;
      result_valid_q <= result_valid_d;
      result_code_q  <= result_code_d;
    end
  end

  assign fire_ready      = (state_q == ST_IDLE) && !game_over_q;
  assign shot            = shot_q;
  assign ship_sunk       = ship_sunk_q;
  assign result_valid    = result_valid_q;
  assign result_code     = result_code_q;
  assign ships_remaining = ships_rem_q;
  assign game_over       = game_over_q;

endmodule

// File: tb/tb_shot_resolver.sv
// Directed self-checking bench for shot_resolver (honours SUNK_ADJACENT_EN when defined).
module tb_shot_resolver;
  import battleship_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         fire_valid;
  logic         fire_ready;
  logic [3:0]   fire_row;
  logic [3:0]   fire_col;
  logic [299:0] ship_map;
  logic [99:0]  is_ship;
  logic [99:0]  shot;
  logic [99:0]  ship_sunk;
  logic         result_valid;
  logic [1:0]   result_code;
  logic [2:0]   ships_remaining;
  logic         game_over;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0]  obs_code;
  int          obs_lat;
  int          obs_shot_lat;
  int          obs_shot_cnt;
  logic [99:0] obs_shot_vec;
  int          obs_sunk_lat;
  int          obs_sunk_cnt;
  logic [99:0] obs_sunk_vec;
  logic [99:0] one_hot_base = 100'd1;

  shot_resolver dut (
    .clk             (clk),
    .reset           (reset),
    .fire_valid      (fire_valid),
    .fire_ready      (fire_ready),
    .fire_row        (fire_row),
    .fire_col        (fire_col),
    .ship_map        (ship_map),
    .is_ship         (is_ship),
    .shot            (shot),
    .ship_sunk       (ship_sunk),
    .result_valid    (result_valid),
    .result_code     (result_code),
    .ships_remaining (ships_remaining),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Ships 1..5 at rows 0,2,4,6 and cells 98/99; ids 7 and 6 at cells 55 and 77 act as water.
  function automatic logic [299:0] build_default_map();
    logic [299:0] m = '0;
    for (int i = 0; i < 5; i++) m[(0 + i) * 3 +: 3] = 3'd1;
    for (int i = 0; i < 4; i++) m[(20 + i) * 3 +: 3] = 3'd2;
    for (int i = 0; i < 3; i++) m[(40 + i) * 3 +: 3] = 3'd3;
    for (int i = 0; i < 3; i++) m[(60 + i) * 3 +: 3] = 3'd4;
    m[98 * 3 +: 3] = 3'd5;
    m[99 * 3 +: 3] = 3'd5;
    m[55 * 3 +: 3] = 3'd7;
    m[77 * 3 +: 3] = 3'd6;
    return m;
  endfunction

  function automatic logic [99:0] expected_is_ship();
    logic [99:0] v = '0;
    for (int i = 0; i < 5; i++) v[i] = 1'b1;
    for (int i = 20; i < 24; i++) v[i] = 1'b1;
    for (int i = 40; i < 43; i++) v[i] = 1'b1;
    for (int i = 60; i < 63; i++) v[i] = 1'b1;
    v[98] = 1'b1;
    v[99] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    fire_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one request and records pulse timing, counted in negedges after the accept edge.
  task automatic do_fire(input logic [3:0] r, input logic [3:0] c);
    int guard;
    obs_code     = '0;
    obs_lat      = -1;
    obs_shot_lat = -1;
    obs_shot_cnt = 0;
    obs_shot_vec = '0;
    obs_sunk_lat = -1;
    obs_sunk_cnt = 0;
    obs_sunk_vec = '0;
    guard        = 0;
    while (!fire_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!fire_ready) return;
    fire_valid = 1'b1;
    fire_row   = r;
    fire_col   = c;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      fire_valid = 1'b0;
      if (shot != '0) begin
        obs_shot_cnt++;
        if (obs_shot_lat < 0) begin
          obs_shot_lat = n;
          obs_shot_vec = shot;
        end
      end
      if (ship_sunk != '0) begin
        obs_sunk_cnt++;
        if (obs_sunk_lat < 0) begin
          obs_sunk_lat = n;
          obs_sunk_vec = ship_sunk;
        end
      end
      if (result_valid) begin
        obs_code = result_code;
        obs_lat  = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tests_run++; if (shot !== '0) begin tests_failed++; $display("[TB] FAIL reset_shot: got %h required 0", shot); end
    tests_run++; if (ship_sunk !== '0) begin tests_failed++; $display("[TB] FAIL reset_sunk: got %h required 0", ship_sunk); end
    tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_result_valid: got %b required 0", result_valid); end
    tests_run++; if (result_code !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_result_code: got %0d required 0", result_code); end
    tests_run++; if (ships_remaining !== 3'd5) begin tests_failed++; $display("[TB] FAIL reset_ships_remaining: got %0d required 5", ships_remaining); end
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_game_over: got %b required 0", game_over); end
    tests_run++; if (fire_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_fire_ready: got %b required 1", fire_ready); end
    tests_run++; if (is_ship !== '0) begin tests_failed++; $display("[TB] FAIL reset_is_ship_water: got %h required 0", is_ship); end
  endtask

  task automatic test_miss();
    do_fire(4'd0, 4'd0);
    tests_run++; if (obs_code !== RES_MISS) begin tests_failed++; $display("[TB] FAIL miss_code: got %0d required %0d", obs_code, RES_MISS); end
    tests_run++; if (obs_lat !== 3) begin tests_failed++; $display("[TB] FAIL miss_latency: got %0d required 3", obs_lat); end
    tests_run++; if (obs_shot_lat !== 2) begin tests_failed++; $display("[TB] FAIL miss_shot_cycle: got %0d required 2", obs_shot_lat); end
    tests_run++; if (obs_shot_vec !== one_hot_base) begin tests_failed++; $display("[TB] FAIL miss_shot_vec: got %h required %h", obs_shot_vec, one_hot_base); end
    tests_run++; if (obs_shot_cnt !== 1) begin tests_failed++; $display("[TB] FAIL miss_shot_width: got %0d required 1", obs_shot_cnt); end
    tests_run++; if (obs_sunk_cnt !== 0) begin tests_failed++; $display("[TB] FAIL miss_no_sunk: got %0d required 0", obs_sunk_cnt); end
    tests_run++; if (ships_remaining !== 3'd5) begin tests_failed++; $display("[TB] FAIL miss_ships_remaining: got %0d required 5", ships_remaining); end
  endtask

  task automatic test_water_ids();
    logic [99:0] exp_ship = expected_is_ship();
    tests_run++; if (is_ship !== exp_ship) begin tests_failed++; $display("[TB] FAIL is_ship_map: got %h required %h", is_ship, exp_ship); end
    do_fire(4'd5, 4'd5);
    tests_run++; if (obs_code !== RES_MISS) begin tests_failed++; $display("[TB] FAIL id7_water_code: got %0d required %0d", obs_code, RES_MISS); end
    tests_run++; if (obs_shot_vec !== (one_hot_base << 55)) begin tests_failed++; $display("[TB] FAIL id7_shot_vec: got %h required %h", obs_shot_vec, one_hot_base << 55); end
    do_fire(4'd7, 4'd7);
    tests_run++; if (obs_code !== RES_MISS) begin tests_failed++; $display("[TB] FAIL id6_water_code: got %0d required %0d", obs_code, RES_MISS); end
    tests_run++; if (ships_remaining !== 3'd5) begin tests_failed++; $display("[TB] FAIL water_ships_remaining: got %0d required 5", ships_remaining); end
  endtask

  task automatic test_hit_sunk();
    logic [99:0] exp_mask = '0;
    exp_mask[98] = 1'b1;
    exp_mask[99] = 1'b1;
`ifdef SUNK_ADJACENT_EN
    exp_mask[87] = 1'b1;
    exp_mask[88] = 1'b1;
    exp_mask[89] = 1'b1;
    exp_mask[97] = 1'b1;
`endif
    do_fire(4'd9, 4'd8);
    tests_run++; if (obs_code !== RES_HIT) begin tests_failed++; $display("[TB] FAIL hit_code: got %0d required %0d", obs_code, RES_HIT); end
    tests_run++; if (obs_lat !== 3) begin tests_failed++; $display("[TB] FAIL hit_latency: got %0d required 3", obs_lat); end
    tests_run++; if (obs_shot_vec !== (one_hot_base << 98)) begin tests_failed++; $display("[TB] FAIL hit_shot_vec: got %h required %h", obs_shot_vec, one_hot_base << 98); end
    tests_run++; if (obs_sunk_cnt !== 0) begin tests_failed++; $display("[TB] FAIL hit_no_sunk: got %0d required 0", obs_sunk_cnt); end
    do_fire(4'd9, 4'd9);
    tests_run++; if (obs_code !== RES_SUNK) begin tests_failed++; $display("[TB] FAIL sunk_code: got %0d required %0d", obs_code, RES_SUNK); end
    tests_run++; if (obs_lat !== 4) begin tests_failed++; $display("[TB] FAIL sunk_latency: got %0d required 4", obs_lat); end
    tests_run++; if (obs_shot_lat !== 2) begin tests_failed++; $display("[TB] FAIL sunk_shot_cycle: got %0d required 2", obs_shot_lat); end
    tests_run++; if (obs_sunk_lat !== 3) begin tests_failed++; $display("[TB] FAIL sunk_pulse_cycle: got %0d required 3", obs_sunk_lat); end
    tests_run++; if (obs_sunk_cnt !== 1) begin tests_failed++; $display("[TB] FAIL sunk_pulse_width: got %0d required 1", obs_sunk_cnt); end
    tests_run++; if (obs_shot_vec !== (one_hot_base << 99)) begin tests_failed++; $display("[TB] FAIL sunk_shot_vec: got %h required %h", obs_shot_vec, one_hot_base << 99); end
    tests_run++; if (obs_sunk_vec !== exp_mask) begin tests_failed++; $display("[TB] FAIL sunk_mask: got %h required %h", obs_sunk_vec, exp_mask); end
    tests_run++; if (ships_remaining !== 3'd4) begin tests_failed++; $display("[TB] FAIL sunk_ships_remaining: got %0d required 4", ships_remaining); end
    tests_run++; if (game_over !== 1'b0) begin tests_failed++; $display("[TB] FAIL sunk_game_over: got %b required 0", game_over); end
  endtask

  task automatic test_reject();
    do_fire(4'd9, 4'd8);
    tests_run++; if (obs_code !== RES_REJECT) begin tests_failed++; $display("[TB] FAIL refire_code: got %0d required %0d", obs_code, RES_REJECT); end
    tests_run++; if (obs_lat !== 2) begin tests_failed++; $display("[TB] FAIL refire_latency: got %0d required 2", obs_lat); end
    tests_run++; if (obs_shot_cnt !== 0) begin tests_failed++; $display("[TB] FAIL refire_no_shot: got %0d required 0", obs_shot_cnt); end
    tests_run++; if (ships_remaining !== 3'd4) begin tests_failed++; $display("[TB] FAIL refire_ships_remaining: got %0d required 4", ships_remaining); end
    do_fire(4'd10, 4'd3);
    tests_run++; if (obs_code !== RES_REJECT) begin tests_failed++; $display("[TB] FAIL row10_code: got %0d required %0d", obs_code, RES_REJECT); end
    tests_run++; if (obs_shot_cnt !== 0) begin tests_failed++; $display("[TB] FAIL row10_no_shot: got %0d required 0", obs_shot_cnt); end
    do_fire(4'd3, 4'd10);
    tests_run++; if (obs_code !== RES_REJECT) begin tests_failed++; $display("[TB] FAIL col10_code: got %0d required %0d", obs_code, RES_REJECT); end
  endtask

  task automatic test_game_over();
    int cells [15] = '{0, 1, 2, 3, 4, 20, 21, 22, 23, 40, 41, 42, 60, 61, 62};
    logic [1:0] exp_code;
    int exp_left;
    int bad_cycles;
    exp_left = 4;
    for (int i = 0; i < 15; i++) begin
      do_fire(4'(cells[i] / 10), 4'(cells[i] % 10));
      exp_code = (i == 4 || i == 8 || i == 11 || i == 14) ? RES_SUNK : RES_HIT;
      tests_run++; if (obs_code !== exp_code) begin tests_failed++; $display("[TB] FAIL sweep_code cell %0d: got %0d required %0d", cells[i], obs_code, exp_code); end
      if (exp_code == RES_SUNK) begin
        exp_left--;
        tests_run++; if (int'(ships_remaining) !== exp_left) begin tests_failed++; $display("[TB] FAIL sweep_ships_remaining cell %0d: got %0d required %0d", cells[i], ships_remaining, exp_left); end
      end
    end
    tests_run++; if (game_over !== 1'b1) begin tests_failed++; $display("[TB] FAIL game_over_flag: got %b required 1", game_over); end
    @(negedge clk);
    fire_valid = 1'b1;
    fire_row   = 4'd5;
    fire_col   = 4'd6;
    bad_cycles = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (fire_ready !== 1'b0 || result_valid !== 1'b0 || shot !== '0) bad_cycles++;
    end
    fire_valid = 1'b0;
    tests_run++; if (bad_cycles !== 0) begin tests_failed++; $display("[TB] FAIL game_over_blocks_fire: got %0d active cycles required 0", bad_cycles); end
    tests_run++; if (game_over !== 1'b1) begin tests_failed++; $display("[TB] FAIL game_over_sticky: got %b required 1", game_over); end
  endtask

  task automatic test_reset_mid();
    int bad_cycles;
    do_reset();
    fire_valid = 1'b1;
    fire_row   = 4'd2;
    fire_col   = 4'd1;
    @(posedge clk);
    @(negedge clk);
    fire_valid = 1'b0;
    @(posedge clk);
    #2;
    tests_run++; if (shot !== (one_hot_base << 21)) begin tests_failed++; $display("[TB] FAIL midreset_shot_before: got %h required %h", shot, one_hot_base << 21); end
    reset = 1'b1;
    #1;
    tests_run++; if (shot !== '0) begin tests_failed++; $display("[TB] FAIL midreset_shot_cleared: got %h required 0", shot); end
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b0;
    bad_cycles = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (result_valid !== 1'b0 || shot !== '0 || ship_sunk !== '0) bad_cycles++;
    end
    tests_run++; if (bad_cycles !== 0) begin tests_failed++; $display("[TB] FAIL midreset_no_pulses: got %0d active cycles required 0", bad_cycles); end
    tests_run++; if (ships_remaining !== 3'd5) begin tests_failed++; $display("[TB] FAIL midreset_ships_remaining: got %0d required 5", ships_remaining); end
    tests_run++; if (fire_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_fire_ready: got %b required 1", fire_ready); end
    do_fire(4'd2, 4'd1);
    tests_run++; if (obs_code !== RES_HIT) begin tests_failed++; $display("[TB] FAIL midreset_refire_code: got %0d required %0d", obs_code, RES_HIT); end
    tests_run++; if (obs_shot_vec !== (one_hot_base << 21)) begin tests_failed++; $display("[TB] FAIL midreset_refire_shot: got %h required %h", obs_shot_vec, one_hot_base << 21); end
  endtask

  initial begin
    reset      = 1'b1;
    fire_valid = 1'b0;
    fire_row   = 4'd0;
    fire_col   = 4'd0;
    ship_map   = '0;
    do_reset();
    test_reset();
    test_miss();
    ship_map = build_default_map();
    do_reset();
    test_water_ids();
    test_hit_sunk();
    test_reject();
    test_game_over();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
